hazard_control_unit: RTL and testbench
======================================

HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 Port clk  input  1  pipeline clock; all state updates on rising edge.
REQ-002 Port reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-003 Port A1_E, A2_E  input  5 each  rs1/rs2 of instruction in Execute.
REQ-004 Port UseA_E, UseB_E  input  1 each  Execute instruction reads rs1/rs2.
REQ-005 Port A3_W  input  5  ALU destination of instruction in Writeback.
REQ-006 Port RegWE_E_W  input  1  Writeback instruction wrote A3_W from the ALU path.
REQ-007 Port A4_W  input  5  load destination in Writeback.
REQ-008 Port RegWE_W_W  input  1  Writeback instruction is a load writing A4_W.
REQ-009 Port MemReqW, MemReadyW  input  1 each  Writeback memory access pending / data memory ready.
REQ-010 Port PCSrcE  input  2  branch/jump redirect from Execute; 00 = PC+4.
REQ-011 Port StallF, StallD, StallE, StallW  output  1 each  stage hold.
REQ-012 Port FlushD, FlushE, FlushW  output  1 each  stage bubble insert.
REQ-013 Port fwdA_E, fwdB_E  output  2 each  00 = register file, 01 = ALUResultW, 10 = load stall buffer; 11 never driven.
REQ-014 Port KillWE_E  output  1  Execute register-file write must be suppressed this cycle.
REQ-015 Port StallCount  output  16  saturating count of stalled cycles.

Function
REQ-016 FSM states RUN, LDSTALL, MEMWAIT; encoding left to implementation.
REQ-017 MEMWAIT entry: MemReqW=1 and MemReadyW=0, from any state; stays while MemReadyW=0; exits to RUN on MemReadyW=1.
REQ-018 MEMWAIT outputs: StallF/D/E/W=1, all Flush=0, KillWE_E=1.
REQ-019 Load-use hazard = RegWE_W_W & A4_W!=0 & ((UseA_E & A1_E==A4_W) | (UseB_E & A2_E==A4_W)).
REQ-020 In RUN with a load-use hazard and no MEMWAIT condition: go to LDSTALL; combinationally drive StallF/D/E=1, FlushW=1, KillWE_E=1 in the same cycle.
REQ-021 LDSTALL lasts exactly one cycle, then returns to RUN; the hazard is not re-evaluated against the bubble now in W.
REQ-022 An internal buffer holds (v, rd). It loads {RegWE_W_W & MemReadyW, A4_W} every cycle in which StallW=0, and clears v otherwise.
REQ-023 fwdA_E = 01 when RegWE_E_W & A3_W!=0 & A3_W==A1_E.
REQ-024 Otherwise fwdA_E = 10 when buffer v & rd!=0 & rd==A1_E.
REQ-025 Otherwise fwdA_E = 00; fwdB_E follows REQ-023..024 identically using A2_E; 01 has priority over 10.
REQ-026 A redirect is PCSrcE!=00 & StallE=0; it drives FlushD=1 and FlushE=1 that cycle, with no stall.
REQ-027 A redirect while stalled (MEMWAIT or load-use) is deferred until the cycle StallE=0.
REQ-028 Register x0 never matches for hazards or forwarding.
REQ-029 StallCount increments by 1 each cycle StallF=1 and holds at 16'hFFFF.
REQ-030 Forward selects are purely combinational from current inputs and buffer state.
REQ-031 Stall, flush and KillWE_E are combinational from current state and current inputs; no added latency.

Reset
REQ-032 reset=0 asynchronously forces: state RUN, buffer v=0, rd=0, StallCount=0.
REQ-033 During reset all Stall/Flush outputs, KillWE_E = 0 and fwdA_E/fwdB_E = 00, regardless of inputs.
REQ-034 Reset asserted mid-LDSTALL or mid-MEMWAIT aborts it; the first cycle after release is RUN.

Verification
REQ-035 ALU back-to-back: A3_W=5, RegWE_E_W=1, A1_E=5, UseA_E=1 -> fwdA_E=01, no stall, StallCount unchanged.
REQ-036 Load-use: RegWE_W_W=1, A4_W=7, MemReadyW=1, A2_E=7, UseB_E=1 -> cycle N: StallF/D/E=1, FlushW=1, KillWE_E=1; cycle N+1: RUN, fwdB_E=10, no stall; StallCount=1.
REQ-037 Memory wait: MemReqW=1, MemReadyW=0 for 3 cycles -> all four Stall=1 for exactly 3 cycles, then RUN; StallCount=3.
REQ-038 Branch: PCSrcE=01, no hazard -> FlushD=FlushE=1 for one cycle; with concurrent load-use, the flush appears in the cycle after the stall.
REQ-039 x0 / priority: A1_E=0 with A3_W=0 -> fwdA_E=00; with A3_W=rd=9 and buffer v=1 -> fwdA_E=01.
REQ-040 Reset asserted during MEMWAIT -> all outputs 0 immediately; after release with MemReadyW=1 -> RUN, StallCount=0.

Source files
------------

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: load-use stalls, memory-wait stalls, redirect flushes and
// operand-forward selection for a four-stage (F/D/E/W) pipeline.
module hazard_control_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1_E,
    input  logic [4:0]  A2_E,
    input  logic        UseA_E,
    input  logic        UseB_E,
    input  logic [4:0]  A3_W,
    input  logic        RegWE_E_W,
    input  logic [4:0]  A4_W,
    input  logic        RegWE_W_W,
    input  logic        MemReqW,
    input  logic        MemReadyW,
    input  logic [1:0]  PCSrcE,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallW,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushW,
    output logic [1:0]  fwdA_E,
    output logic [1:0]  fwdB_E,
    output logic        KillWE_E,
    output logic [15:0] StallCount
);

    typedef enum logic [1:0] {
        StRun     = 2'b00,
        StLdStall = 2'b01,
        StMemWait = 2'b10
    } state_e;

    localparam logic [1:0]  FwdRegFile = 2'b00;
    localparam logic [1:0]  FwdAluW    = 2'b01;
    localparam logic [1:0]  FwdLoadBuf = 2'b10;
    localparam logic [15:0] CountMax   = 16'hFFFF;

    state_e      state_q, state_d;
    logic        buf_v_q, buf_v_d;
    logic [4:0]  buf_rd_q, buf_rd_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic mem_cond;
    logic load_use;
    logic redirect_req;
    logic stall_f, stall_d, stall_e, stall_w;
    logic flush_d, flush_e, flush_w;
    logic kill_we;
    logic [1:0] fwd_a, fwd_b;

    // Load-use hazard: x0 never matches.
    always_comb begin
        load_use = RegWE_W_W && (A4_W != 5'd0) &&
                   ((UseA_E && (A1_E == A4_W)) || (UseB_E && (A2_E == A4_W)));
        mem_cond     = MemReqW && !MemReadyW;
        redirect_req = (PCSrcE != 2'b00);
    end

    // Next state and raw (pre-reset-gating) control outputs.
    always_comb begin
        state_d = state_q;
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_w = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_w = 1'b0;
        kill_we = 1'b0;

        unique case (state_q)
            StRun: begin
                if (mem_cond) begin
                    state_d = StMemWait;
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    stall_e = 1'b1;
                    stall_w = 1'b1;
                    kill_we = 1'b1;
                end else if (load_use) begin
                    // Hold F/D/E, push a bubble into W; any redirect waits for E to move.
                    state_d = StLdStall;
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    stall_e = 1'b1;
                    flush_w = 1'b1;
                    kill_we = 1'b1;
                end else begin
                    flush_d = redirect_req;
                    flush_e = redirect_req;
                end
            end
            StLdStall: begin
                // The bubble now in W is not re-checked for a hazard.
                if (mem_cond) begin
                    state_d = StMemWait;
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    stall_e = 1'b1;
                    stall_w = 1'b1;
                    kill_we = 1'b1;
                end else begin
                    state_d = StRun;
                    flush_d = redirect_req;
                    flush_e = redirect_req;
                end
            end
            StMemWait: begin
                if (!MemReadyW) begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    stall_e = 1'b1;
                    stall_w = 1'b1;
                    kill_we = 1'b1;
                end else begin
                    state_d = StRun;
                    flush_d = redirect_req;
                    flush_e = redirect_req;
                end
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    // Forwarding: ALU result in W wins over the load stall buffer.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src);
        logic [1:0] sel;
        sel = FwdRegFile;
        if (RegWE_E_W && (A3_W != 5'd0) && (A3_W == src)) begin
            sel = FwdAluW;
        end else if (buf_v_q && (buf_rd_q != 5'd0) && (buf_rd_q == src)) begin
            sel = FwdLoadBuf;
        end
        return sel;
    endfunction

    always_comb begin
        fwd_a = fwd_sel(A1_E);
        fwd_b = fwd_sel(A2_E);
    end

    // Buffer captures the retiring load whenever W advances.
    always_comb begin
        buf_rd_d = buf_rd_q;
        buf_v_d  = 1'b0;
        if (!stall_w) begin
            buf_v_d  = RegWE_W_W && MemReadyW;
            buf_rd_d = A4_W;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_f && (stall_cnt_q != CountMax)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StRun;
            buf_v_q     <= 1'b0;
            buf_rd_q    <= 5'd0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            buf_v_q     <= buf_v_d;
            buf_rd_q    <= buf_rd_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Outputs are forced quiet while reset is held, whatever the inputs do.
    always_comb begin
        StallF     = reset && stall_f;
        StallD     = reset && stall_d;
        StallE     = reset && stall_e;
        StallW     = reset && stall_w;
        FlushD     = reset && flush_d;
        FlushE     = reset && flush_e;
        FlushW     = reset && flush_w;
        KillWE_E   = reset && kill_we;
        fwdA_E     = reset ? fwd_a : FwdRegFile;
        fwdB_E     = reset ? fwd_b : FwdRegFile;
        StallCount = stall_cnt_q;
    end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit: per-cycle model comparison plus
// hand-computed checks for the directed scenarios.
module tb_hazard_control_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  A1_E, A2_E, A3_W, A4_W;
    logic        UseA_E, UseB_E, RegWE_E_W, RegWE_W_W, MemReqW, MemReadyW;
    logic [1:0]  PCSrcE;
    logic        StallF, StallD, StallE, StallW, FlushD, FlushE, FlushW, KillWE_E;
    logic [1:0]  fwdA_E, fwdB_E;
    logic [15:0] StallCount;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    // Model state: "waiting on memory", "stalled for load-use last cycle", load buffer, count.
    bit m_wait, m_ld, m_bv;
    int m_brd, m_cnt;
    bit e_mem, e_lu, e_redir;

    hazard_control_unit dut (
        .clk(clk), .reset(reset),
        .A1_E(A1_E), .A2_E(A2_E), .UseA_E(UseA_E), .UseB_E(UseB_E),
        .A3_W(A3_W), .RegWE_E_W(RegWE_E_W), .A4_W(A4_W), .RegWE_W_W(RegWE_W_W),
        .MemReqW(MemReqW), .MemReadyW(MemReadyW), .PCSrcE(PCSrcE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallW(StallW),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .fwdA_E(fwdA_E), .fwdB_E(fwdB_E), .KillWE_E(KillWE_E), .StallCount(StallCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cycle, got, exp);
        end
    endtask

    function automatic int model_fwd(input int src);
        if (RegWE_E_W && A3_W != 0 && int'(A3_W) == src) return 1;
        if (m_bv && m_brd != 0 && m_brd == src) return 2;
        return 0;
    endfunction

    // Compare every output against the model at the falling edge.
    task automatic sample();
        bit hz;
        @(negedge clk);
        if (!reset) begin
            m_wait = 0; m_ld = 0; m_bv = 0; m_brd = 0; m_cnt = 0;
            e_mem = 0; e_lu = 0; e_redir = 0;
            chk("rst_StallF", StallF, 0);  chk("rst_StallW", StallW, 0);
            chk("rst_FlushD", FlushD, 0);  chk("rst_FlushW", FlushW, 0);
            chk("rst_Kill", KillWE_E, 0);  chk("rst_fwdA", fwdA_E, 0);
            chk("rst_fwdB", fwdB_E, 0);    chk("rst_count", StallCount, 0);
            return;
        end
        hz = RegWE_W_W && A4_W != 0 &&
             ((UseA_E && A1_E == A4_W) || (UseB_E && A2_E == A4_W));
        e_mem   = (MemReqW && !MemReadyW) || (m_wait && !MemReadyW);
        e_lu    = !e_mem && !m_wait && !m_ld && hz;
        e_redir = PCSrcE != 0 && !(e_mem || e_lu);
        chk("StallF", StallF, e_mem || e_lu);
        chk("StallD", StallD, e_mem || e_lu);
        chk("StallE", StallE, e_mem || e_lu);
        chk("StallW", StallW, e_mem);
        chk("FlushD", FlushD, e_redir);
        chk("FlushE", FlushE, e_redir);
        chk("FlushW", FlushW, e_lu);
        chk("KillWE_E", KillWE_E, e_mem || e_lu);
        chk("fwdA_E", fwdA_E, model_fwd(A1_E));
        chk("fwdB_E", fwdB_E, model_fwd(A2_E));
        chk("StallCount", StallCount, m_cnt);
    endtask

    task automatic advance();
        @(posedge clk);
        cycle++;
        if (reset) begin
            if (!e_mem) begin
                m_bv  = RegWE_W_W && MemReadyW;
                m_brd = A4_W;
            end else begin
                m_bv = 0;
            end
            if ((e_mem || e_lu) && m_cnt < 65535) m_cnt++;
            m_wait = e_mem;
            m_ld   = e_lu;
        end
        #1;
    endtask

    task automatic cyc();
        sample();
        advance();
    endtask

    task automatic idle();
        A1_E = 0; A2_E = 0; A3_W = 0; A4_W = 0; UseA_E = 0; UseB_E = 0;
        RegWE_E_W = 0; RegWE_W_W = 0; MemReqW = 0; MemReadyW = 1; PCSrcE = 0;
    endtask

    initial begin
        // Reset with hostile inputs: outputs must stay quiet.
        idle();
        reset = 0; MemReqW = 1; MemReadyW = 0; RegWE_W_W = 1; A4_W = 3; A1_E = 3;
        UseA_E = 1; RegWE_E_W = 1; A3_W = 3; PCSrcE = 2'b10;
        cyc(); cyc();
        #1 reset = 1; idle();
        sample(); chk("lit_post_reset_count", StallCount, 16'd0); advance();

        // ALU back-to-back forward.
        A3_W = 5; RegWE_E_W = 1; A1_E = 5; UseA_E = 1;
        sample(); chk("lit_alu_fwdA", fwdA_E, 2'b01); chk("lit_alu_nostall", StallF, 0);
        advance();
        idle();
        sample(); chk("lit_alu_count", StallCount, 16'd0); advance();

        // Load-use on rs2.
        RegWE_W_W = 1; A4_W = 7; MemReadyW = 1; A2_E = 7; UseB_E = 1;
        sample();
        chk("lit_lu_StallF", StallF, 1); chk("lit_lu_StallE", StallE, 1);
        chk("lit_lu_StallW", StallW, 0); chk("lit_lu_FlushW", FlushW, 1);
        chk("lit_lu_Kill", KillWE_E, 1);
        advance();
        RegWE_W_W = 0; A4_W = 0;
        sample();
        chk("lit_lu_fwdB", fwdB_E, 2'b10); chk("lit_lu_nostall", StallF, 0);
        chk("lit_lu_count", StallCount, 16'd1);
        advance();
        idle(); cyc();

        // Memory wait for three cycles.
        MemReqW = 1; MemReadyW = 0;
        for (int i = 0; i < 3; i++) begin
            sample(); chk("lit_mem_StallW", StallW, 1); chk("lit_mem_Kill", KillWE_E, 1);
            chk("lit_mem_FlushD", FlushD, 0); advance();
        end
        MemReadyW = 1;
        sample(); chk("lit_mem_release", StallF, 0); chk("lit_mem_count", StallCount, 16'd4);
        advance();
        idle(); cyc();

        // Branch without hazard, then with concurrent load-use.
        PCSrcE = 2'b01;
        sample(); chk("lit_br_FlushD", FlushD, 1); chk("lit_br_FlushE", FlushE, 1); advance();
        idle();
        sample(); chk("lit_br_once", FlushD, 0); advance();
        PCSrcE = 2'b01; RegWE_W_W = 1; A4_W = 4; A1_E = 4; UseA_E = 1;
        sample(); chk("lit_brlu_noflush", FlushD, 0); chk("lit_brlu_stall", StallE, 1);
        advance();
        RegWE_W_W = 0; A4_W = 0;
        sample(); chk("lit_brlu_flushD", FlushD, 1); chk("lit_brlu_flushE", FlushE, 1);
        advance();
        idle(); cyc();

        // x0 and forwarding priority.
        A1_E = 0; A3_W = 0; RegWE_E_W = 1; UseA_E = 1;
        sample(); chk("lit_x0_fwdA", fwdA_E, 2'b00); advance();
        idle(); RegWE_W_W = 1; A4_W = 9; cyc();
        RegWE_W_W = 1; A4_W = 9; A3_W = 9; RegWE_E_W = 1; A1_E = 9;
        sample(); chk("lit_prio_fwdA", fwdA_E, 2'b01); advance();
        idle(); A1_E = 9;
        sample(); chk("lit_buf_fwdA", fwdA_E, 2'b10); advance();
        idle(); cyc();

        // Reset in the middle of a memory wait.
        MemReqW = 1; MemReadyW = 0;
        cyc(); cyc();
        reset = 0;
        sample(); chk("lit_rst_mw_StallF", StallF, 0); chk("lit_rst_mw_count", StallCount, 0);
        advance();
        reset = 1; MemReqW = 1; MemReadyW = 1;
        sample(); chk("lit_rst_rel_StallF", StallF, 0); chk("lit_rst_rel_count", StallCount, 0);
        advance();
        idle(); cyc();

        // Saturation of the stall counter.
        MemReqW = 1; MemReadyW = 0;
        for (int i = 0; i < 65540; i++) cyc();
        idle();
        sample(); chk("lit_sat_count", StallCount, 16'hFFFF); advance();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
